ifm_feed_ctrl: RTL and testbench
================================

IFM_FEED_CTRL -- requirements
Module: ifm_feed_ctrl

Interface
REQ-001 SHALL have parameters: INPUT_WIDTH, 512, AXIS word width; OUTPUT_WIDTH, 64, slice width; SLICES, INPUT_WIDTH/OUTPUT_WIDTH, slices per word; CNT_W, 16, word-counter width.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- conv_start  in  1  start pulse, honoured only in IDLE
- num_words  in  CNT_W  words in this run, sampled with conv_start
- s_axis_tdata  in  INPUT_WIDTH  input word
- s_axis_tvalid  in  1  input word valid
- s_axis_tready  out  1  controller accepts word
- cons_ready  in  1  downstream takes current slice this cycle
- fm  out  INPUT_WIDTH  held word driven to the slice parser
- slice_valid  out  1  fm[slice_idx] valid for downstream
- slice_idx  out  clog2(SLICES)  current slice index
- ifm_read  out  1  slice advance strobe to parser
- init_word  out  1  first AXIS handshake of a run
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, STREAM, DONE.
REQ-005 IDLE: conv_start=1 and num_words!=0 -> FETCH, words_left<=num_words, first<=1; conv_start=1 and num_words==0 -> DONE; otherwise stay.
REQ-006 FETCH: s_axis_tready=1; on tvalid&tready: fm<=tdata, slice_idx<=0, first<=0, -> STREAM.
REQ-007 STREAM: slice_valid=1; ifm_read = slice_valid & cons_ready, combinational.
REQ-008 Each ifm_read with slice_idx<SLICES-1 SHALL increment slice_idx.
REQ-009 ifm_read with slice_idx==SLICES-1 SHALL decrement words_left; if words_left==1 -> DONE.
REQ-010 Back-to-back: in STREAM, s_axis_tready = (slice_idx==SLICES-1) & cons_ready & (words_left>1), combinational; on handshake fm<=tdata, slice_idx<=0, stay STREAM (zero bubble).
REQ-011 Last slice consumed with words_left>1 and no handshake SHALL go to FETCH, slice_idx<=0.
REQ-012 init_word = s_axis_tvalid & s_axis_tready & first, combinational; exactly once per run.
REQ-013 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE and DONE, 1 in FETCH and STREAM.
REQ-014 s_axis_tready SHALL be 0 in IDLE and DONE; slice_valid and ifm_read SHALL be 0 outside STREAM.
REQ-015 conv_start outside IDLE SHALL be ignored; num_words changes after sampling SHALL have no effect.
REQ-016 fm SHALL hold its value while cons_ready=0 and between runs.
REQ-017 Total ifm_read pulses per run SHALL equal num_words*SLICES; total AXIS handshakes SHALL equal num_words.
REQ-018 words_left SHALL never wrap below 0; num_words=2^CNT_W-1 SHALL run to completion.

Reset
REQ-019 rst_n=0 at a clock edge SHALL force state IDLE, fm=0, slice_idx=0, words_left=0, first=0; all outputs 0 from the following cycle, including mid-run.
REQ-020 After reset release, no AXIS handshake SHALL occur until a new conv_start.

Verification
REQ-021 SLICES=8, num_words=1, tvalid and cons_ready held 1: conv_start -> init_word 1 cycle, 8 ifm_read with slice_idx 0..7, done 1 cycle later, busy drops.
REQ-022 num_words=3, tvalid and cons_ready held 1: 24 consecutive ifm_read cycles with no gap; tready high only on slice 7 of words 1-2; done after 24th read.
REQ-023 num_words=2, tvalid=0 during word-1 slice 7 -> FETCH entered, slice_valid=0 until tvalid returns; fm updates only on handshake.
REQ-024 cons_ready toggling 1010...: slice_idx advances only on cons_ready=1 cycles; fm stable; 16 reads for num_words=2.
REQ-025 conv_start with num_words=0 -> done pulse next cycle, tready never asserted; conv_start during STREAM ignored.
REQ-026 rst_n=0 at slice_idx=4 of word 2 -> next cycle all outputs 0, state IDLE; fresh run of num_words=1 completes normally.

Source files
------------

// File: rtl/ifm_feed_ctrl.sv
// Input feature-map feed controller: fetches AXIS words and hands them out one slice at a time.
// Zero-bubble refill when the last slice of a word is consumed in the same cycle as the next handshake.
module ifm_feed_ctrl #(
    parameter int unsigned INPUT_WIDTH  = 512,
    parameter int unsigned OUTPUT_WIDTH = 64,
    parameter int unsigned SLICES       = INPUT_WIDTH / OUTPUT_WIDTH,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned IDX_W       = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   conv_start,
    input  logic [CNT_W-1:0]       num_words,
    input  logic [INPUT_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   cons_ready,
    output logic [INPUT_WIDTH-1:0] fm,
    output logic                   slice_valid,
    output logic [IDX_W-1:0]       slice_idx,
    output logic                   ifm_read,
    output logic                   init_word,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);
    localparam logic [CNT_W-1:0] ONE_WORD = CNT_W'(1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       words_left_q, words_left_d;
    logic                   first_q, first_d;
    logic [INPUT_WIDTH-1:0] fm_q, fm_d;
    logic [IDX_W-1:0]       slice_idx_q, slice_idx_d;

    logic last_slice;
    logic handshake;

    assign last_slice  = (slice_idx_q == LAST_IDX);
    assign slice_valid = (state_q == STREAM);
    assign ifm_read    = slice_valid & cons_ready;
    assign busy        = (state_q == FETCH) | (state_q == STREAM);
    assign done        = (state_q == DONE);
    assign fm          = fm_q;
    assign slice_idx   = slice_idx_q;

    // In STREAM the next word may only be accepted as the current last slice leaves.
    always_comb begin
        s_axis_tready = 1'b0;
        if (state_q == FETCH) begin
            s_axis_tready = 1'b1;
        end else if (state_q == STREAM) begin
            s_axis_tready = last_slice & cons_ready & (words_left_q > ONE_WORD);
        end
    end

    assign handshake = s_axis_tvalid & s_axis_tready;
    assign init_word = handshake & first_q;

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        first_d      = first_q;
        fm_d         = fm_q;
        slice_idx_d  = slice_idx_q;
        case (state_q)
            IDLE: begin
                if (conv_start) begin
                    if (num_words != '0) begin
                        state_d      = FETCH;
                        words_left_d = num_words;
                        first_d      = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (handshake) begin
                    fm_d        = s_axis_tdata;
                    slice_idx_d = '0;
                    first_d     = 1'b0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (ifm_read) begin
                    if (!last_slice) begin
                        slice_idx_d = slice_idx_q + IDX_W'(1);
                    end else begin
                        if (words_left_q != '0) begin
                            words_left_d = words_left_q - ONE_WORD;
                        end
                        slice_idx_d = '0;
                        if (words_left_q <= ONE_WORD) begin
                            state_d = DONE;
                        end else if (handshake) begin
                            fm_d    = s_axis_tdata;
                            first_d = 1'b0;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            first_q      <= 1'b0;
            fm_q         <= '0;
            slice_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            first_q      <= first_d;
            fm_q         <= fm_d;
            slice_idx_q  <= slice_idx_d;
        end
    end

endmodule

// File: tb/tb_ifm_feed_ctrl.sv
// Bench for ifm_feed_ctrl: randomized runs checked against a word-queue model of the slice feed.
module tb_ifm_feed_ctrl;

    localparam int unsigned IW = 512;
    localparam int unsigned OW = 64;
    localparam int unsigned SL = IW / OW;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          conv_start;
    logic [CW-1:0] num_words;
    logic [IW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          cons_ready;
    logic [IW-1:0] fm;
    logic          slice_valid;
    logic [2:0]    slice_idx;
    logic          ifm_read;
    logic          init_word;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ifm_feed_ctrl #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .SLICES      (SL),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .conv_start   (conv_start),
        .num_words    (num_words),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .cons_ready   (cons_ready),
        .fm           (fm),
        .slice_valid  (slice_valid),
        .slice_idx    (slice_idx),
        .ifm_read     (ifm_read),
        .init_word    (init_word),
        .busy         (busy),
        .done         (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: words accepted but not yet fully consumed, plus what fm should be holding.
    logic [IW-1:0] acc_q[$];
    logic [IW-1:0] model_fm;
    logic [IW-1:0] next_tdata;
    bit            busy_exp;
    int reads, hs, inits, rd_in_word, tready_hi, fetch_cycles, first_rd, last_rd;

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] w;
        for (int i = 0; i < int'(IW / 32); i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic run_words(input int n, input int tv_mode, input int cr_mode, input bit poke);
        bit exp_sv, exp_rd, exp_tr, hsk;
        int stall;
        int cycles;
        acc_q.delete();
        reads = 0; hs = 0; inits = 0; rd_in_word = 0; tready_hi = 0; fetch_cycles = 0;
        first_rd = -1; last_rd = -1; stall = 0; cycles = 0;
        @(posedge clk); #1;
        conv_start = 1'b1; num_words = CW'(n); s_axis_tvalid = 1'b1; cons_ready = 1'b1;
        s_axis_tdata = next_tdata;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || s_axis_tready !== 1'b0 || slice_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_idle: busy=%b tready=%b sv=%b done=%b, required all 0",
                     busy, s_axis_tready, slice_valid, done);
        end
        n_checks++;
        if (fm !== model_fm) begin
            n_fail++;
            $display("FAIL fm_hold_between_runs: got %h required %h", fm, model_fm);
        end
        busy_exp = (n != 0);
        while (reads < n * int'(SL)) begin
            @(posedge clk); #1;
            conv_start = poke && (cycles == 5);
            num_words  = CW'($urandom());
            case (tv_mode)
                0: s_axis_tvalid = 1'b1;
                1: s_axis_tvalid = ($urandom_range(0, 3) != 0);
                default: begin
                    s_axis_tvalid = !(hs == 1 && stall < 3);
                    if (hs == 1 && acc_q.size() == 0 && stall < 3) stall++;
                end
            endcase
            case (cr_mode)
                0: cons_ready = 1'b1;
                1: cons_ready = ($urandom_range(0, 3) != 0);
                default: cons_ready = (cycles % 2 == 0);
            endcase
            s_axis_tdata = next_tdata;
            @(negedge clk);
            exp_sv = (acc_q.size() != 0);
            exp_rd = exp_sv && cons_ready;
            exp_tr = busy_exp && (!exp_sv || (rd_in_word == int'(SL) - 1 && cons_ready && hs < n));
            hsk    = s_axis_tvalid && exp_tr;
            n_checks++;
            if (slice_valid !== exp_sv) begin
                n_fail++;
                $display("FAIL slice_valid: got %b required %b", slice_valid, exp_sv);
            end
            n_checks++;
            if (busy !== busy_exp) begin
                n_fail++;
                $display("FAIL busy: got %b required %b", busy, busy_exp);
            end
            n_checks++;
            if (fm !== model_fm) begin
                n_fail++;
                $display("FAIL fm: got %h required %h", fm, model_fm);
            end
            if (exp_sv) begin
                n_checks++;
                if (slice_idx !== 3'(rd_in_word)) begin
                    n_fail++;
                    $display("FAIL slice_idx: got %0d required %0d", slice_idx, rd_in_word);
                end
            end
            n_checks++;
            if (ifm_read !== exp_rd) begin
                n_fail++;
                $display("FAIL ifm_read: got %b required %b", ifm_read, exp_rd);
            end
            n_checks++;
            if (s_axis_tready !== exp_tr) begin
                n_fail++;
                $display("FAIL tready: got %b required %b (slice %0d, accepted %0d of %0d)",
                         s_axis_tready, exp_tr, rd_in_word, hs, n);
            end
            n_checks++;
            if (init_word !== (hsk && hs == 0)) begin
                n_fail++;
                $display("FAIL init_word: got %b required %b", init_word, hsk && hs == 0);
            end
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_early: got %b required 0", done);
            end
            if (s_axis_tready === 1'b1) tready_hi++;
            if (!exp_sv) fetch_cycles++;
            if (init_word === 1'b1) inits++;
            if (exp_rd) begin
                reads++;
                if (first_rd < 0) first_rd = cycles;
                last_rd = cycles;
                rd_in_word++;
                if (rd_in_word == int'(SL)) begin
                    rd_in_word = 0;
                    void'(acc_q.pop_front());
                end
            end
            if (hsk) begin
                acc_q.push_back(s_axis_tdata);
                model_fm   = s_axis_tdata;
                hs++;
                next_tdata = rand_word();
            end
            cycles++;
            if (cycles > 4000) begin
                n_checks++; n_fail++;
                $display("FAIL run_timeout: got %0d reads required %0d", reads, n * int'(SL));
                break;
            end
        end
        busy_exp = 1'b0;
        @(posedge clk); #1;
        conv_start = 1'b0; s_axis_tvalid = 1'b1; cons_ready = $urandom_range(0, 1);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || s_axis_tready !== 1'b0 || slice_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b tready=%b sv=%b, required 1 0 0 0",
                     done, busy, s_axis_tready, slice_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b busy=%b tready=%b, required 0 0 0",
                     done, busy, s_axis_tready);
        end
        n_checks++;
        if (hs !== n || inits !== ((n != 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL run_totals: handshakes %0d init_words %0d, required %0d and %0d",
                     hs, inits, n, (n != 0) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; conv_start = 1'b1; num_words = 16'd3;
        s_axis_tvalid = 1'b1; cons_ready = 1'b1; s_axis_tdata = rand_word();
        repeat (3) @(posedge clk);
        #1;
        conv_start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fm !== '0 || slice_idx !== 3'd0 || slice_valid !== 1'b0 || ifm_read !== 1'b0 ||
            s_axis_tready !== 1'b0 || init_word !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: fm=%h idx=%0d sv=%b rd=%b tr=%b iw=%b busy=%b done=%b",
                     fm, slice_idx, slice_valid, ifm_read, s_axis_tready, init_word, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (s_axis_tready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL no_handshake_after_reset: tready=%b busy=%b required 0 0",
                         s_axis_tready, busy);
            end
        end
        model_fm = '0;
    endtask

    task automatic test_single_word();
        run_words(1, 0, 0, 0);
        n_checks++;
        if (first_rd !== 1 || last_rd !== 8) begin
            n_fail++;
            $display("FAIL single_word_timing: reads at %0d..%0d required 1..8", first_rd, last_rd);
        end
    endtask

    task automatic test_back_to_back();
        run_words(3, 0, 0, 0);
        n_checks++;
        if (last_rd - first_rd !== 23 || tready_hi !== 3) begin
            n_fail++;
            $display("FAIL back_to_back: read span %0d tready cycles %0d, required 23 and 3",
                     last_rd - first_rd, tready_hi);
        end
    endtask

    task automatic test_stall_fetch();
        run_words(2, 3, 0, 0);
        n_checks++;
        if (fetch_cycles !== 5) begin
            n_fail++;
            $display("FAIL stall_fetch: %0d cycles without a held word, required 5", fetch_cycles);
        end
    endtask

    task automatic test_cons_toggle();
        run_words(2, 0, 2, 0);
        n_checks++;
        if (last_rd - first_rd !== 30) begin
            n_fail++;
            $display("FAIL cons_toggle_span: got %0d required 30", last_rd - first_rd);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        run_words(0, 0, 0, 0);
        run_words(2, 0, 0, 1);
    endtask

    task automatic test_mid_run_reset();
        int r;
        int guard;
        r = 0;
        guard = 0;
        @(posedge clk); #1;
        conv_start = 1'b1; num_words = 16'd2; s_axis_tvalid = 1'b1; cons_ready = 1'b1;
        @(posedge clk); #1;
        conv_start = 1'b0;
        forever begin
            @(negedge clk);
            if (r == int'(SL) + 4) break;
            if (ifm_read === 1'b1) r++;
            guard++;
            if (guard > 100) break;
            @(posedge clk); #1;
        end
        n_checks++;
        if (slice_idx !== 3'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_position: idx=%0d busy=%b required 4 1", slice_idx, busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fm !== '0 || slice_idx !== 3'd0 || slice_valid !== 1'b0 || ifm_read !== 1'b0 ||
            s_axis_tready !== 1'b0 || init_word !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: fm=%h idx=%0d sv=%b rd=%b tr=%b iw=%b busy=%b done=%b",
                     fm, slice_idx, slice_valid, ifm_read, s_axis_tready, init_word, busy, done);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (s_axis_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL tready_after_mid_reset: got %b required 0", s_axis_tready);
            end
        end
        model_fm = '0;
        run_words(1, 0, 0, 0);
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 8; i++) begin
            run_words($urandom_range(1, 6), 1, 1, ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        next_tdata = rand_word();
        model_fm   = '0;
        busy_exp   = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall_fetch();
        test_cons_toggle();
        test_zero_and_ignored_start();
        test_mid_run_reset();
        test_random_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
